// File: rtl/opl3_pkg.sv
// opl3_pkg: shared OPL3 host-bus types, phase encodings and default strobe timing.
package opl3_pkg;
  localparam int HOST_DW = 8;
  localparam int HOST_WR_PULSE_CYCLES = 2;
  localparam int HOST_ADDR_GAP_CYCLES = 4;
  localparam int HOST_DATA_GAP_CYCLES = 4;
  localparam int HOST_RD_PULSE_CYCLES = 2;
  localparam logic HOST_ADDR_PHASE = 1'b0;
  localparam logic HOST_DATA_PHASE = 1'b1;
  typedef struct packed {
    logic               rd;
    logic               bank;
    logic [HOST_DW-1:0] reg_addr;
    logic [HOST_DW-1:0] data;
  } host_cmd_t;
  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR_STB, ST_ADDR_GAP, ST_DATA_STB, ST_DATA_GAP, ST_RD_STB
  } host_seq_state_t;
endpackage

// File: rtl/host_bus_sequencer.sv
// host_bus_sequencer: turns write/read commands into timed OPL3 host-bus strobe sequences.
module host_bus_sequencer
  import opl3_pkg::*;
#(
  parameter int DATA_WIDTH      = HOST_DW,
  parameter int WR_PULSE_CYCLES = HOST_WR_PULSE_CYCLES,
  parameter int ADDR_GAP_CYCLES = HOST_ADDR_GAP_CYCLES,
  parameter int DATA_GAP_CYCLES = HOST_DATA_GAP_CYCLES,
  parameter int RD_PULSE_CYCLES = HOST_RD_PULSE_CYCLES
) (
  input  logic                  clk_host,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_rd,
  input  logic                  cmd_bank,
  input  logic [DATA_WIDTH-1:0] cmd_reg,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  busy,
  output logic                  cs_n,
  output logic                  rd_n,
  output logic                  wr_n,
  output logic [1:0]            address,
  output logic [DATA_WIDTH-1:0] din,
  input  logic [DATA_WIDTH-1:0] dout
);
  localparam int MAX_AB = WR_PULSE_CYCLES > ADDR_GAP_CYCLES ? WR_PULSE_CYCLES : ADDR_GAP_CYCLES;
  localparam int MAX_CD = DATA_GAP_CYCLES > RD_PULSE_CYCLES ? DATA_GAP_CYCLES : RD_PULSE_CYCLES;
  localparam int CW = $clog2((MAX_AB > MAX_CD ? MAX_AB : MAX_CD) + 1);
  localparam logic [CW-1:0] WR_LD = CW'(WR_PULSE_CYCLES - 1);
  localparam logic [CW-1:0] AG_LD = CW'(ADDR_GAP_CYCLES - 1);
  localparam logic [CW-1:0] DG_LD = CW'(DATA_GAP_CYCLES - 1);
  localparam logic [CW-1:0] RD_LD = CW'(RD_PULSE_CYCLES - 1);

  if (WR_PULSE_CYCLES < 1 || ADDR_GAP_CYCLES < 1 || DATA_GAP_CYCLES < 1 || RD_PULSE_CYCLES < 1) begin : g_bad_timing
    $error("host_bus_sequencer: every pulse and gap length must be >= 1");
  end
  if (DATA_WIDTH != HOST_DW) begin : g_bad_width
    $error("host_bus_sequencer: DATA_WIDTH must match the OPL3 bus width");
  end

  host_seq_state_t       r_state, w_nxt;
  logic [CW-1:0]         r_cnt, w_cnt_nxt, w_load;
  host_cmd_t             r_cmd, w_cmd;
  logic                  w_accept, w_done;
  logic                  r_cs_n, r_rd_n, r_wr_n, r_rsp_valid;
  logic [1:0]            r_address, w_addr_nxt;
  logic [DATA_WIDTH-1:0] r_din, w_din_nxt, r_rsp_data;

  assign cmd_ready = r_state == ST_IDLE && !reset;
  assign w_accept  = cmd_valid && cmd_ready;
  assign w_done    = r_cnt == '0;
  // The command being accepted this cycle drives the first strobe directly; later phases use the latch.
  assign w_cmd     = w_accept ? '{rd: cmd_rd, bank: cmd_bank, reg_addr: cmd_reg, data: cmd_data} : r_cmd;
  assign busy      = r_state != ST_IDLE;
  assign cs_n      = r_cs_n;
  assign rd_n      = r_rd_n;
  assign wr_n      = r_wr_n;
  assign address   = r_address;
  assign din       = r_din;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_IDLE:                w_nxt = w_accept ? (w_cmd.rd ? ST_RD_STB : ST_ADDR_STB) : ST_IDLE;
      ST_ADDR_STB:            w_nxt = w_done ? ST_ADDR_GAP : ST_ADDR_STB;
      ST_ADDR_GAP:            w_nxt = w_done ? ST_DATA_STB : ST_ADDR_GAP;
      ST_DATA_STB:            w_nxt = w_done ? ST_DATA_GAP : ST_DATA_STB;
      ST_DATA_GAP, ST_RD_STB: w_nxt = w_done ? ST_IDLE : r_state;
      default:                w_nxt = ST_IDLE;
    endcase
    w_load = (w_nxt == ST_ADDR_STB || w_nxt == ST_DATA_STB) ? WR_LD :
             w_nxt == ST_ADDR_GAP ? AG_LD :
             w_nxt == ST_DATA_GAP ? DG_LD :
             w_nxt == ST_RD_STB   ? RD_LD : '0;
    w_cnt_nxt = w_nxt != r_state ? w_load : w_done ? '0 : r_cnt - 1'b1;
    w_addr_nxt = w_nxt == ST_RD_STB   ? 2'b00 :
                 w_nxt == ST_ADDR_STB ? {w_cmd.bank, HOST_ADDR_PHASE} :
                 w_nxt == ST_DATA_STB ? {w_cmd.bank, HOST_DATA_PHASE} : r_address;
    w_din_nxt = w_nxt == ST_ADDR_STB ? w_cmd.reg_addr :
                w_nxt == ST_DATA_STB ? w_cmd.data : r_din;
  end

  always_ff @(posedge clk_host) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk_host) begin
    if (reset) begin
      r_cmd       <= '0;
      r_cs_n      <= 1'b1;
      r_rd_n      <= 1'b1;
      r_wr_n      <= 1'b1;
      r_address   <= '0;
      r_din       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_cmd       <= w_cmd;
      r_cs_n      <= !(w_nxt inside {ST_ADDR_STB, ST_DATA_STB, ST_RD_STB});
      r_wr_n      <= !(w_nxt inside {ST_ADDR_STB, ST_DATA_STB});
      r_rd_n      <= w_nxt != ST_RD_STB;
      r_address   <= w_addr_nxt;
      r_din       <= w_din_nxt;
      r_rsp_valid <= r_state == ST_RD_STB && w_done;
      if (r_state == ST_RD_STB && w_done) r_rsp_data <= dout;
    end
  end
endmodule

// File: tb/tb_host_bus_sequencer.sv
// tb_host_bus_sequencer: checks default and minimum-timing sequencers against a per-cycle bus trace model.
module tb_host_bus_sequencer;
  localparam int D_W = 2, D_AG = 4, D_DG = 4, D_R = 2;
  localparam int F_W = 1, F_AG = 1, F_DG = 1, F_R = 1;

  logic       clk_host = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0, f_valid = 1'b0;
  logic       cmd_rd = 1'b0, cmd_bank = 1'b0;
  logic [7:0] cmd_reg = '0, cmd_data = '0, dout = '0;
  logic       d_ready, d_rsp_valid, d_busy, d_cs_n, d_rd_n, d_wr_n;
  logic       f_ready, f_rsp_valid, f_busy, f_cs_n, f_rd_n, f_wr_n;
  logic [1:0] d_address, f_address;
  logic [7:0] d_rsp_data, d_din, f_rsp_data, f_din;
  logic [15:0] d_obs, f_obs;
  int n_cmp = 0, n_err = 0;
  logic [7:0] pd_d = '0, pd_f = '0;
  logic       nxt_rd, nxt_bank;
  logic [7:0] nxt_reg, nxt_data;

  always #5 clk_host = ~clk_host;

  host_bus_sequencer #(.DATA_WIDTH(8), .WR_PULSE_CYCLES(D_W), .ADDR_GAP_CYCLES(D_AG),
                       .DATA_GAP_CYCLES(D_DG), .RD_PULSE_CYCLES(D_R)) u_dflt (
    .clk_host(clk_host), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(d_ready),
    .cmd_rd(cmd_rd), .cmd_bank(cmd_bank), .cmd_reg(cmd_reg), .cmd_data(cmd_data),
    .rsp_valid(d_rsp_valid), .rsp_data(d_rsp_data), .busy(d_busy), .cs_n(d_cs_n),
    .rd_n(d_rd_n), .wr_n(d_wr_n), .address(d_address), .din(d_din), .dout(dout));

  host_bus_sequencer #(.DATA_WIDTH(8), .WR_PULSE_CYCLES(F_W), .ADDR_GAP_CYCLES(F_AG),
                       .DATA_GAP_CYCLES(F_DG), .RD_PULSE_CYCLES(F_R)) u_fast (
    .clk_host(clk_host), .reset(reset), .cmd_valid(f_valid), .cmd_ready(f_ready),
    .cmd_rd(cmd_rd), .cmd_bank(cmd_bank), .cmd_reg(cmd_reg), .cmd_data(cmd_data),
    .rsp_valid(f_rsp_valid), .rsp_data(f_rsp_data), .busy(f_busy), .cs_n(f_cs_n),
    .rd_n(f_rd_n), .wr_n(f_wr_n), .address(f_address), .din(f_din), .dout(dout));

  assign d_obs = {d_cs_n, d_rd_n, d_wr_n, d_address, d_din, d_busy, d_ready, d_rsp_valid};
  assign f_obs = {f_cs_n, f_rd_n, f_wr_n, f_address, f_din, f_busy, f_ready, f_rsp_valid};

  // Expected {cs_n,rd_n,wr_n,address,din,busy,ready,rsp_valid} k cycles after acceptance.
  function automatic logic [15:0] model(int w, int ag, int dg, int r, bit rd, bit bank,
                                        logic [7:0] rg, logic [7:0] dt, logic [7:0] pd, int k);
    int occ;
    bit rdn, wrn, ph;
    logic [7:0] d;
    occ = rd ? r : 2 * w + ag + dg;
    rdn = !(rd && k <= r);
    wrn = !(!rd && (k <= w || (k > w + ag && k <= 2 * w + ag)));
    ph  = k > w + ag;
    d   = rd ? pd : (ph ? dt : rg);
    return {rdn & wrn, rdn, wrn, rd ? 1'b0 : bank, rd ? 1'b0 : ph, d, k <= occ, k > occ, rd && k == occ + 1};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Caller has already driven the command; checks k = 1..occupancy+1 after the accepting edge.
  task automatic run(input bit rd, input bit bank, input logic [7:0] rg, input logic [7:0] dt,
                     input logic [7:0] dv, input bit use_f, input bit keep, input int stop_k);
    int occ_d, occ_f, n;
    occ_d = rd ? D_R : 2 * D_W + D_AG + D_DG;
    occ_f = rd ? F_R : 2 * F_W + F_AG + F_DG;
    n = occ_d + 1;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk_host);
      if (k == 1) begin
        f_valid = 1'b0;
        if (keep) begin
          cmd_rd = nxt_rd; cmd_bank = nxt_bank; cmd_reg = nxt_reg; cmd_data = nxt_data;
        end else begin
          cmd_valid = 1'b0;
          cmd_rd = 1'($urandom); cmd_bank = 1'($urandom);
          cmd_reg = 8'($urandom); cmd_data = 8'($urandom);
        end
      end
      check($sformatf("dflt k=%0d", k), d_obs, model(D_W, D_AG, D_DG, D_R, rd, bank, rg, dt, pd_d, k));
      if (rd && k == occ_d + 1) check("dflt rsp_data", {8'h00, d_rsp_data}, {8'h00, dv});
      if (use_f) begin
        check($sformatf("fast k=%0d", k), f_obs, model(F_W, F_AG, F_DG, F_R, rd, bank, rg, dt, pd_f, k));
        if (rd && k == occ_f + 1) check("fast rsp_data", {8'h00, f_rsp_data}, {8'h00, dv});
      end
      if (k == stop_k) return;
    end
    if (!rd) pd_d = dt;
    if (use_f && !rd) pd_f = dt;
  endtask

  task automatic issue(input bit rd, input bit bank, input logic [7:0] rg, input logic [7:0] dt,
                       input logic [7:0] dv, input bit use_f);
    cmd_rd = rd; cmd_bank = bank; cmd_reg = rg; cmd_data = dt; dout = dv;
    cmd_valid = 1'b1; f_valid = use_f;
    run(rd, bank, rg, dt, dv, use_f, 1'b0, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk_host);
    check("reset dflt", d_obs, 16'hE000);
    check("reset fast", f_obs, 16'hE000);
    check("reset rsp_data", {d_rsp_data, f_rsp_data}, 16'h0000);
    reset = 1'b0;
    @(negedge clk_host);
    check("idle dflt", d_obs, 16'hE002);
    check("idle fast", f_obs, 16'hE002);
    issue(1'b0, 1'b0, 8'h20, 8'h01, 8'h00, 1'b1);
    issue(1'b0, 1'b1, 8'h05, 8'h01, 8'h00, 1'b1);
    issue(1'b1, 1'b0, 8'h00, 8'h00, 8'hE0, 1'b1);
    cmd_rd = 1'b0; cmd_bank = 1'b0; cmd_reg = 8'hB0; cmd_data = 8'h2A;
    nxt_rd = 1'b0; nxt_bank = 1'b1; nxt_reg = 8'hA0; nxt_data = 8'h15;
    cmd_valid = 1'b1;
    run(1'b0, 1'b0, 8'hB0, 8'h2A, 8'h00, 1'b0, 1'b1, 0);
    run(1'b0, 1'b1, 8'hA0, 8'h15, 8'h00, 1'b0, 1'b0, 0);
    cmd_rd = 1'b0; cmd_bank = 1'b0; cmd_reg = 8'h20; cmd_data = 8'h01; cmd_valid = 1'b1;
    run(1'b0, 1'b0, 8'h20, 8'h01, 8'h00, 1'b0, 1'b0, 7);
    reset = 1'b1;
    @(negedge clk_host);
    check("reset mid dflt", d_obs, 16'hE000);
    reset = 1'b0;
    @(negedge clk_host);
    check("after reset dflt", d_obs, 16'hE002);
    check("after reset fast", f_obs, 16'hE002);
    pd_d = '0; pd_f = '0;
    issue(1'b0, 1'b0, 8'h20, 8'h01, 8'h00, 1'b1);
    for (int i = 0; i < 24; i++)
      issue(1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
